// File: rtl/pipe_pkg.sv
// Shared constants and handshake state type for the asynchronous pipeline sink.
`default_nettype none

package pipe_pkg;

  localparam int DATA_W_DEF      = 3;
  localparam int FIFO_DEPTH_DEF  = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int LEVEL_W         = $clog2(FIFO_DEPTH_DEF) + 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACK_HI = 1'b1
  } hs_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous control bit.
`default_nettype none

module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/async_pipe_sink.sv
// Receives 4-phase bundled-data tokens from an asynchronous stage into a
// clocked FIFO with a valid/ready output side.
`default_nettype none

module async_pipe_sink
  import pipe_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        temp_req_in,
  input  logic [DATA_W-1:0]           temp_data_in,
  output logic                        temp_ack_out,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = ADDR_W + 1;

  logic              req_s;
  hs_state_e         state_q, state_d;
  logic              ack_q, ack_d;
  logic [LVL_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  occ;
  logic              full, empty, push, pop;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  sync_ff #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (temp_req_in),
    .q_o   (req_s)
  );

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign occ   = wr_ptr_q - rd_ptr_q;
  assign full  = (occ == LVL_W'(FIFO_DEPTH));
  assign empty = (occ == '0);
  assign pop   = !empty && out_ready;

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        ack_d = 1'b0;
        if (req_s && !full) begin
          push    = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK_HI;
        end
      end
      ACK_HI: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= temp_data_in;
  end

  assign temp_ack_out = ack_q;
  assign out_valid    = !empty;
  assign level        = occ;
  // Storage is not reset, so the head is masked while empty.
  assign out_data     = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];

endmodule

`default_nettype wire

// File: tb/tb_async_pipe_sink.sv
// Self-checking bench: vector table, handshake corner cases and a queue-based
// reference model under random back-pressure.
`default_nettype none

module tb_async_pipe_sink;
  import pipe_pkg::*;

  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic [DW-1:0] din;
  logic          ack;
  logic [DW-1:0] dout;
  logic          valid;
  logic          ready;
  logic [2:0]    level;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  async_pipe_sink #(.DATA_W(3), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .temp_req_in  (req),
    .temp_data_in (din),
    .temp_ack_out (ack),
    .out_data     (dout),
    .out_valid    (valid),
    .out_ready    (ready),
    .level        (level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 1'b0;
    din   = '0;
    ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input logic val, input int maxc, output int n);
    n = 0;
    while (ack !== val && n < maxc) begin
      tick();
      n++;
    end
    chk(val ? "ack_rise_seen" : "ack_fall_seen", 32'(ack), 32'(val));
  endtask

  // One full 4-phase cycle; returns edges from req rise to ack rise and from req fall to ack fall.
  task automatic send(input logic [DW-1:0] d, output int lat_up, output int lat_dn);
    din = d;
    req = 1'b1;
    wait_ack(1'b1, 100, lat_up);
    req = 1'b0;
    wait_ack(1'b0, 100, lat_dn);
  endtask

  task automatic stream(input int ntok, input bit fixed_data);
    int popped;
    int cyc;
    exp_q.delete();
    popped = 0;
    cyc    = 0;
    fork
      begin
        int lu, ld;
        logic [DW-1:0] d;
        for (int i = 0; i < ntok; i++) begin
          d = fixed_data ? DW'(i % 8) : DW'($urandom_range(0, 7));
          exp_q.push_back(d);
          send(d, lu, ld);
        end
      end
      begin
        logic r;
        while (popped < ntok && cyc < 3000) begin
          chk("level_bound", 32'(level <= 3'd4), 32'd1);
          chk("valid_vs_level", 32'(valid), 32'(level != 3'd0));
          r = 1'($urandom_range(0, 1));
          ready = r;
          if (valid && r) begin
            if (exp_q.size() == 0) chk("pop_without_token", 32'd1, 32'd0);
            else chk("stream_order", 32'(dout), 32'(exp_q.pop_front()));
            popped++;
          end
          tick();
          cyc++;
        end
        ready = 1'b0;
      end
    join
    chk("stream_count", 32'(popped), 32'(ntok));
  endtask

  typedef struct {
    logic [DW-1:0] d;
    bit            pop_after;
    int            exp_level;
    logic [DW-1:0] exp_head;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lu, ld;
    logic [DW-1:0] got[$];
    bit saw_ack;

    tbl[0] = '{3'd5, 1'b0, 1, 3'd5};
    tbl[1] = '{3'd2, 1'b0, 2, 3'd5};
    tbl[2] = '{3'd7, 1'b1, 2, 3'd2};
    tbl[3] = '{3'd0, 1'b1, 2, 3'd7};
    tbl[4] = '{3'd6, 1'b0, 3, 3'd7};
    tbl[5] = '{3'd1, 1'b0, 4, 3'd7};

    // Reset values, checked while reset is still asserted
    rst_n = 1'b0; req = 1'b0; din = '0; ready = 1'b0;
    #3;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_data", 32'(dout), 32'd0);
    do_reset();

    // Single token with the consumer ready
    ready = 1'b1; din = 3'b101; req = 1'b1;
    tick(); chk("single_e1_ack", 32'(ack), 32'd0);
    tick(); chk("single_e2_ack", 32'(ack), 32'd0);
    tick(); chk("single_e3_ack", 32'(ack), 32'd1);
    chk("single_valid", 32'(valid), 32'd1);
    chk("single_data", 32'(dout), 32'd5);
    req = 1'b0;
    tick(); chk("single_popped_level", 32'(level), 32'd0);
    chk("single_ack_hold1", 32'(ack), 32'd1);
    tick(); chk("single_ack_hold2", 32'(ack), 32'd1);
    tick(); chk("single_ack_fall", 32'(ack), 32'd0);
    ready = 1'b0;

    // Vector table
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].d, lu, ld);
      chk($sformatf("vec%0d_lat_up", i), 32'(lu), 32'd3);
      chk($sformatf("vec%0d_lat_dn", i), 32'(ld), 32'd3);
      if (tbl[i].pop_after) begin
        ready = 1'b1;
        tick();
        ready = 1'b0;
      end
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].exp_level));
      chk($sformatf("vec%0d_head", i), 32'(dout), 32'(tbl[i].exp_head));
    end

    // Fill to capacity, then release back-pressure
    do_reset();
    for (int i = 1; i <= 4; i++) send(DW'(i), lu, ld);
    chk("fill_level", 32'(level), 32'd4);
    din = 3'd5; req = 1'b1;
    repeat (10) tick();
    chk("fill_ack_withheld", 32'(ack), 32'd0);
    chk("fill_level_held", 32'(level), 32'd4);
    ready = 1'b1;
    saw_ack = 1'b0;
    got.delete();
    for (int c = 0; c < 40 && got.size() < 5; c++) begin
      if (ack) begin
        saw_ack = 1'b1;
        req = 1'b0;
      end
      if (valid) got.push_back(dout);
      tick();
    end
    ready = 1'b0;
    chk("fill_fifth_ack", 32'(saw_ack), 32'd1);
    chk("fill_pop_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < got.size(); i++) chk($sformatf("fill_pop%0d", i), 32'(got[i]), 32'(i + 1));
    req = 1'b0;
    wait_ack(1'b0, 100, ld);
    chk("fill_drained", 32'(level), 32'd0);

    // Push and pop on the same edge
    do_reset();
    send(3'd3, lu, ld);
    send(3'd6, lu, ld);
    chk("conc_pre_level", 32'(level), 32'd2);
    din = 3'd1; req = 1'b1;
    tick(); tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("conc_ack", 32'(ack), 32'd1);
    chk("conc_level", 32'(level), 32'd2);
    chk("conc_head", 32'(dout), 32'd6);
    req = 1'b0;
    wait_ack(1'b0, 100, ld);
    ready = 1'b1;
    chk("conc_order0", 32'(dout), 32'd6);
    tick();
    chk("conc_order1", 32'(dout), 32'd1);
    tick();
    chk("conc_empty", 32'(level), 32'd0);
    ready = 1'b0;

    // Pointer wrap under random back-pressure
    do_reset();
    stream(10, 1'b1);
    do_reset();
    stream(16, 1'b0);

    // Reset while in ACK_HI, then a req held high across release
    do_reset();
    send(3'd2, lu, ld);
    send(3'd4, lu, ld);
    din = 3'd7; req = 1'b1;
    wait_ack(1'b1, 100, lu);
    chk("rmid_level", 32'(level), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmid_ack", 32'(ack), 32'd0);
    chk("rmid_valid", 32'(valid), 32'd0);
    chk("rmid_level0", 32'(level), 32'd0);
    chk("rmid_data", 32'(dout), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); chk("rrel_e1_ack", 32'(ack), 32'd0);
    tick(); chk("rrel_e2_ack", 32'(ack), 32'd0);
    tick(); chk("rrel_e3_ack", 32'(ack), 32'd1);
    chk("rrel_level", 32'(level), 32'd1);
    chk("rrel_data", 32'(dout), 32'd7);

    // Held req must not be re-captured
    repeat (20) tick();
    chk("hold_level", 32'(level), 32'd1);
    chk("hold_ack", 32'(ack), 32'd1);
    req = 1'b0;
    wait_ack(1'b0, 100, ld);
    chk("hold_level_after", 32'(level), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/async_pipe_sink.md
ASYNC_PIPE_SINK -- requirements
Module: async_pipe_sink

Interface
REQ-001 Parameter DATA_W, default 3, width of the bundled-data token.
REQ-002 Parameter FIFO_DEPTH, default 4, token buffer entries (power of two, >=2).
REQ-003 Parameter SYNC_STAGES, default 2, flops in the req synchronizer (>=2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 temp_req_in  input  1  4-phase request from the upstream asynchronous stage.
REQ-007 temp_data_in  input  DATA_W  bundled data; stable from req rise until ack rise.
REQ-008 temp_ack_out  output  1  4-phase acknowledge to upstream; registered.
REQ-009 out_data  output  DATA_W  head-of-buffer token.
REQ-010 out_valid  output  1  buffer non-empty.
REQ-011 out_ready  input  1  downstream consumer accepts out_data this cycle.
REQ-012 level  output  clog2(FIFO_DEPTH)+1  current buffer occupancy.

Function
REQ-013 temp_req_in SHALL pass through a SYNC_STAGES flop chain to form req_s; no other logic SHALL sample temp_req_in.
REQ-014 Handshake FSM states: IDLE, ACK_HI.
REQ-015 IDLE: if req_s=1 and buffer not full, push temp_data_in, set temp_ack_out=1, go ACK_HI; otherwise hold, temp_ack_out=0.
REQ-016 ACK_HI: temp_ack_out held 1 until req_s=0; then temp_ack_out=0, go IDLE.
REQ-017 Latency: temp_req_in rise to temp_ack_out rise SHALL be SYNC_STAGES+1 edges when buffer not full.
REQ-018 Back-pressure: buffer full in IDLE SHALL withhold temp_ack_out; the token is pushed on the first edge after a slot frees.
REQ-019 Push decision SHALL use occupancy before the same-cycle pop (no full-buffer pass-through).
REQ-020 Pop when out_valid && out_ready; out_data SHALL be the oldest token, registered-free read of buffer head.
REQ-021 Simultaneous push and pop SHALL leave level unchanged; pop on empty and push on full SHALL never occur.
REQ-022 Read/write pointers SHALL wrap modulo FIFO_DEPTH; level = write count minus read count, range 0..FIFO_DEPTH.
REQ-023 Exactly one push per 4-phase cycle; a req that stays high SHALL NOT be re-captured.

Reset
REQ-024 rst_n=0 SHALL immediately clear: temp_ack_out=0, out_valid=0, level=0, pointers=0, synchronizer=0, state IDLE; out_data = 0.
REQ-025 Reset mid-handshake discards buffered tokens; a temp_req_in still high after release is accepted as a new token.
REQ-026 Reset deassertion is assumed synchronized to clk externally.

Structure
REQ-027 Shared package pipe_pkg SHALL hold DATA_W default, the FSM state enum, and the clog2-based level width constant.
REQ-028 Synchronizer SHALL be sub-module sync_ff (parameter STAGES, async active-low reset); buffer and FSM stay in async_pipe_sink.

Verification
REQ-029 Single token: req rise with data=3'b101, out_ready=1 -> ack rises on edge 3, out_valid=1 with out_data=5 next cycle, ack falls 3 edges after req fall.
REQ-030 Fill: out_ready=0, send tokens 1,2,3,4,5 -> level=4, fifth ack withheld; raise out_ready -> pops 1,2,3,4 in order, fifth ack issued, 5 popped last.
REQ-031 Concurrent: level=2, push and pop same edge -> level stays 2, order preserved.
REQ-032 Wrap: stream 10 tokens (0..7,0,1) with random out_ready -> output sequence identical, level never exceeds 4.
REQ-033 Reset in ACK_HI with level=3 -> ack=0, out_valid=0, level=0 immediately; req held high -> one new token captured after release.
REQ-034 Req held high 20 cycles -> exactly one push, level=1.
